// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, start-bit glitch rejection, break
// lockout, and a first-word-fall-through receive FIFO with a valid/ready port.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW      = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  logic sync1_q;
  logic rxs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Free-running 16x baud tick.
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic       frame_err_q;
  logic       push_c;

  // Good stop bit at mid-bit: the byte is written into the FIFO on this edge.
  assign push_c = (state_q == S_STOP) && tick && (cnt_q == 4'd15) && rxs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxs_q) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
          S_START: begin
            if (cnt_q == 4'd7) begin
              if (!rxs_q) begin
                state_q <= S_DATA;
                cnt_q   <= '0;
                idx_q   <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_DATA: begin
            if (cnt_q == 4'd15) begin
              shift_q[idx_q] <= rxs_q;
              cnt_q          <= '0;
              if (idx_q == 3'd7) begin
                state_q <= S_STOP;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_STOP: begin
            if (cnt_q == 4'd15) begin
              cnt_q <= '0;
              if (rxs_q) begin
                state_q <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_WAIT_HIGH;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_WAIT_HIGH: begin
            if (rxs_q) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Receive FIFO: full push is accepted only when a pop frees the slot.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          overrun_q;
  logic          full_c;
  logic          pop_c;
  logic          accept_c;

  assign full_c   = (count_q == CW'(FIFO_DEPTH));
  assign pop_c    = rx_valid && rx_ready;
  assign accept_c = push_c && (!full_c || pop_c);

  always_comb begin
    count_d = count_q;
    if (accept_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !accept_c) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_c && full_c && !pop_c;
      count_q   <= count_d;
      if (accept_c) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_c) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  assign rx_data   = mem_q[rd_q];
  assign rx_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised bench for uart_rx; expected bytes, frame errors and
// overruns come from a queue-based model of an 8N1 link into a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 6400000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned DEPTH    = 4;
  localparam int          BIT_CLK  = 64;
  localparam int          FRAME_CLK = 10 * BIT_CLK;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Monitor: samples just after each falling edge, when inputs are settled.
  int         cyc = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] got [$];

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  // Link model: accepted bytes in order, FIFO occupancy, expected pulse counts.
  logic [7:0] acc [$];
  int occ = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int cmp_a = 0;
  int cmp_g = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_fe++;
    else if (occ < int'(DEPTH)) begin
      acc.push_back(b);
      occ++;
    end else exp_ov++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain_and_compare(input string tag);
    int guard = 0;
    int n;
    rx_ready = 1'b1;
    while (rx_valid === 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    rx_ready = 1'b0;
    occ = 0;
    chk({tag, "_empty"}, 32'(rx_valid), 32'd0);
    chk({tag, "_count"}, 32'(got.size() - cmp_g), 32'(acc.size() - cmp_a));
    n = acc.size() - cmp_a;
    if (got.size() - cmp_g < n) n = got.size() - cmp_g;
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, 32'(got[cmp_g + i]), 32'(acc[cmp_a + i]));
    cmp_a = acc.size();
    cmp_g = got.size();
  endtask

  initial begin
    int         r0;
    logic       seen;
    logic [7:0] pb;
    logic [7:0] rb;
    int         nb;

    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(20);

    // Single byte held until a one-cycle ready pulse.
    r0 = rise_cnt;
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(8);
    chk("a5_rise", 32'(rise_cnt - r0), 32'd1);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_ferr", 32'(fe_cnt), 32'(exp_fe));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("a5_popped", 32'(rx_valid), 32'd0);
    drain_and_compare("a5");

    // 16-clk low glitch must be rejected mid start bit.
    r0 = rise_cnt;
    seen = 1'b0;
    rx = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 16) rx = 1'b1;
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", 32'(seen), 32'd1);
    chk("glitch_busy_done", 32'(busy), 32'd0);
    idle(200);
    chk("glitch_no_push", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_ferr", 32'(fe_cnt), 32'(exp_fe));

    // Bad stop bit followed by a long break, then a clean frame.
    r0 = rise_cnt;
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (FRAME_CLK) @(negedge clk);
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_no_push", 32'(rise_cnt - r0), 32'd0);
    chk("break_ferr", 32'(fe_cnt), 32'(exp_fe));
    idle(BIT_CLK);
    chk("break_released", 32'(busy), 32'd0);
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(8);
    chk("break_ferr_once", 32'(fe_cnt), 32'(exp_fe));
    drain_and_compare("break");

    // Five back-to-back frames into a 4-deep FIFO with no consumer.
    for (int b = 1; b <= 5; b++) begin
      model_frame(8'(b), 1'b1);
      send_frame(8'(b), 1'b1);
    end
    idle(8);
    chk("ovr_pulse", 32'(ov_cnt), 32'(exp_ov));
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    drain_and_compare("ovr");

    // Full FIFO with a pop on exactly the fifth push edge: nothing dropped.
    idle(BIT_CLK);
    r0 = rise_cnt;
    for (int b = 1; b <= 4; b++) model_frame(8'(b), 1'b1);
    occ--;
    model_frame(8'h05, 1'b1);
    fork
      begin
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
      end
      begin
        int g = 0;
        int tgt;
        while (rise_cnt == r0 && g < 2000) begin
          @(negedge clk);
          g++;
        end
        tgt = rise_cyc + 4 * FRAME_CLK;
        while (cyc < tgt - 2 && g < 6000) begin
          @(negedge clk);
          g++;
        end
        chk("simpop_sync", 32'(cyc), 32'(tgt - 2));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(8);
    chk("simpop_no_ovr", 32'(ov_cnt), 32'(exp_ov));
    drain_and_compare("simpop");

    // Reset in the middle of bit 4 of 0x96, with a byte already queued.
    model_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(16);
    chk("rst_pre_valid", 32'(rx_valid), 32'd1);
    pb = 8'h96;
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = pb[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    while (acc.size() > cmp_a + (got.size() - cmp_g)) void'(acc.pop_back());
    occ = 0;
    idle(400);
    chk("rst_idle_valid", 32'(rx_valid), 32'd0);
    model_frame(8'hC3, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(8);
    drain_and_compare("rst");

    // Random bursts with random idle gaps, sometimes overflowing the FIFO.
    for (int r = 0; r < 3; r++) begin
      nb = int'($urandom_range(1, 6));
      for (int j = 0; j < nb; j++) begin
        rb = 8'($urandom);
        model_frame(rb, 1'b1);
        send_frame(rb, 1'b1);
        idle(int'($urandom_range(0, 40)));
      end
      idle(8);
      chk("rand_ovr", 32'(ov_cnt), 32'(exp_ov));
      chk("rand_busy", 32'(busy), 32'd0);
      drain_and_compare("rand");
    end
    chk("final_ferr", 32'(fe_cnt), 32'(exp_fe));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the debug/UART subsystem; the receive-side counterpart of the existing UART transmit path. It oversamples the asynchronous `UART_RXD` line at 16× baud and deserialises 8N1 frames. Received bytes land in a small first-word-fall-through FIFO with a valid/ready read port, so host-side debug commands can be consumed by a downstream controller on the CPU clock domain.

## Interface
- `CLK_FREQ`, default 100000000: `clk` frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Synchroniser: 2-FF chain on `rx`, both flops reset to 1. The FSM sees only the synchronised value `rxs`.
- Tick generator: `DIV = CLK_FREQ/(BAUD*16)`, truncating integer division, with `DIV` ≥1. A free-running counter runs 0..DIV-1; `tick`=1 in the cycle the counter equals DIV-1. The counter resets to 0.
- 4-bit sample counter `cnt` and 3-bit bit index `idx`; both advance only on `tick`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on `tick` with `rxs`=0, go to START with `cnt`=0.
  - START: on `tick`, if `cnt`=7 (mid start bit): `rxs`=0 → DATA with `cnt`=0, `idx`=0; `rxs`=1 → IDLE (glitch rejected). Otherwise `cnt`++.
  - DATA: on `tick` with `cnt`=15, shift `rxs` into bit `idx` (LSB first) and set `cnt`=0. If `idx`=7, go to STOP; else `idx`++. Otherwise `cnt`++.
  - STOP: on `tick` with `cnt`=15:
    - `rxs`=1 → push the byte, go to IDLE.
    - `rxs`=0 → `frame_err` pulse, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE on the first `tick` with `rxs`=1. This prevents a held-low line (break) from re-triggering reception.
- FIFO: circular buffer with read and write pointers plus an occupancy count of width log2(FIFO_DEPTH)+1.
  - `rx_data` = entry at the read pointer; `rx_valid` = (count≠0).
  - Pop occurs when `rx_valid` & `rx_ready`.
  - A push into a full FIFO is accepted only if a pop happens in the same cycle; the count is unchanged.
  - A push into a full FIFO with no pop drops the new byte and pulses `overrun`. Stored data is never overwritten.
  - Push and pop in the same cycle when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `rx_data`=0 (storage cleared), `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. Reset also sets FSM=IDLE, pointers and count = 0, the tick counter = 0, and the synchroniser to 1.
- `rst` mid-frame aborts the frame immediately and discards any partial byte. Reception restarts on the next falling edge seen after `rst` deasserts.
- Input latency: `rx` to `rxs` is 2 clk.
- Start detection has up to 1 tick (DIV clk) of jitter. Data bits are sampled 8 ticks after the detected edge, ±1 tick.
- Push occurs on the clock edge of the stop-sample tick. `rx_valid` rises, and `rx_data` is valid, the next cycle.
- `frame_err` and `overrun` are high for exactly the one cycle after the stop-sample edge.
- Frame length: 160 ticks = 160·DIV clk. Back-to-back frames (no idle gap) are received without loss, because STOP exits at mid stop bit.
- `busy` is high from the IDLE→START transition until the return to IDLE, including WAIT_HIGH.

## Test plan
Bench parameters: CLK_FREQ=6400000, BAUD=100000, so DIV=4 and one bit = 64 clk. FIFO_DEPTH=4.
- Drive 0xA5 as 8N1 with `rx_ready`=0 → `rx_valid` rises once, `rx_data`=0xA5, `frame_err`=0, `busy` returns to 0. Then pulse `rx_ready` for 1 clk → `rx_valid`=0.
- Hold `rx` low for 16 clk, then high → START rejects the glitch, no push, `busy` back to 0 within 40 clk of the falling edge.
- Send 0x3C with stop bit=0, then hold `rx` low for 640 clk, then high, then send 0x55 → one `frame_err` pulse; no push for 0x3C; no spurious byte while low; 0x55 received.
- Send 0x01..0x05 back-to-back with `rx_ready`=0 → 4 bytes held, one `overrun` pulse at the 5th stop. Draining with `rx_ready`=1 yields 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
- FIFO full (4 bytes) with `rx_ready` asserted exactly on the 5th push cycle → no `overrun`; drain order 0x02, 0x03, 0x04, 0x05.
- Assert `rst` for 1 clk at bit 4 of 0x96 → all outputs at reset values; a following 0xC3 frame is received correctly.
